is_ex_ctrl: RTL and testbench

- Single-slot issue/execute controller that sits directly downstream of the reservation station.
- Accepts one ready instruction from the RS issue packet and reads its operands from the physical register file.
- Sequences the instruction through an ALU (1 cycle), a fixed-latency multiplier, or a variable-latency memory unit.
- Arbitrates for the CDB, then retires the RS entry via EX_RS_PACKET and back-pressures the RS with is_stall while the slot is occupied.

---
 rtl/is_ex_ctrl_pkg.sv | 67 ++++++
 rtl/is_ex_latency_ctr.sv | 30 +++
 rtl/is_ex_ctrl.sv | 147 ++++++++++++++
 tb/tb_is_ex_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/is_ex_ctrl_pkg.sv
// Shared types for the issue/execute slot: decoder/RS packets, FSM state,
// functional-unit classes and the multiply-detect helper used by the RS too.
package is_ex_ctrl_pkg;

  localparam int XLEN         = 32;
  localparam int PRF_W        = 6;
  localparam int RS_IDX_W     = 4;
  localparam int MULT_LAT_DEF = 4;

  typedef logic [XLEN-1:0]     DATA;
  typedef logic [PRF_W-1:0]    PHYS_REG_IDX;
  typedef logic [RS_IDX_W-1:0] RS_IDX;

  typedef struct packed {
    PHYS_REG_IDX phys_reg;
  } TAG;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } ALU_FUNC;

  typedef struct packed {
    RS_IDX   rs_idx;
    ALU_FUNC alu_func;
    logic    rd_mem;
    logic    wr_mem;
    TAG      t1;
    TAG      t2;
    TAG      dest;
  } DECODER_PACKET;

  typedef struct packed {
    logic          issue_en;
    DECODER_PACKET decoder_packet;
  } RS_IS_PACKET;

  typedef struct packed {
    logic  remove_en;
    RS_IDX remove_idx;
  } EX_RS_PACKET;

  typedef enum logic [1:0] {
    IS_EX_IDLE,
    IS_EX_EXEC,
    IS_EX_WB
  } IS_EX_STATE;

  typedef enum logic [1:0] {
    FU_ALU,
    FU_MULT,
    FU_MEM
  } FU_CLASS;

  function automatic logic is_mult(input ALU_FUNC f);
    return (f == ALU_MUL) || (f == ALU_MULH) || (f == ALU_MULHSU) || (f == ALU_MULHU);
  endfunction

  // Memory ops win over the ALU function field, which is don't-care for them.
  function automatic FU_CLASS fu_class_of(input ALU_FUNC f, input logic rd_mem,
                                          input logic wr_mem);
    if (rd_mem || wr_mem) return FU_MEM;
    if (is_mult(f))       return FU_MULT;
    return FU_ALU;
  endfunction

endpackage

// File: rtl/is_ex_latency_ctr.sv
// Down-counter for fixed-latency units; a load value of 0 marks the
// variable-latency (memory) path and the counter then holds at 0.
module is_ex_latency_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/is_ex_ctrl.sv
// Single-slot issue/execute controller: latches one issued instruction,
// times it through ALU/MULT/MEM, then broadcasts on the CDB and retires the RS entry.
module is_ex_ctrl
  import is_ex_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          interrupt,
  input  RS_IS_PACKET   rs_is_packet,
  output logic          is_stall,
  output PHYS_REG_IDX   prf_rd_idx1,
  output PHYS_REG_IDX   prf_rd_idx2,
  input  DATA           prf_rd_data1,
  input  DATA           prf_rd_data2,
  output logic          fu_valid,
  output DECODER_PACKET fu_packet,
  output DATA           fu_opa,
  output DATA           fu_opb,
  input  DATA           fu_result,
  input  logic          mem_done,
  input  DATA           mem_data,
  output logic          cdb_req,
  input  logic          cdb_gnt,
  output TAG            cdb_tag,
  output logic          cdb_en,
  output DATA           cdb_value,
  output EX_RS_PACKET   ex_rs_packet,
  output IS_EX_STATE    dbg_state
);

  IS_EX_STATE    state_q, state_d;
  DECODER_PACKET pkt_q, pkt_d;
  DATA           opa_q, opa_d;
  DATA           opb_q, opb_d;
  DATA           result_q, result_d;
  logic          first_q, first_d;

  logic             fire, accept, in_wb, mem_path;
  logic             ctr_load, ctr_dec, ctr_last;
  logic [CNT_W-1:0] ctr_load_val, ctr_cnt;

  is_ex_latency_ctr #(.CNT_W(CNT_W)) u_latency_ctr (
    .clk_i      (clock),
    .rst_i      (reset || interrupt),
    .load_i     (ctr_load),
    .load_val_i (ctr_load_val),
    .dec_i      (ctr_dec),
    .cnt_o      (ctr_cnt),
    .last_o     (ctr_last)
  );

  // Handshake: the RS offers with issue_en; the slot takes it when !is_stall.
  // is_stall drops in the fire cycle so a new issue can overlap the CDB
  // broadcast, and remove_en/cdb_en are asserted only in that fire cycle.
  assign in_wb    = (state_q == IS_EX_WB);
  assign fire     = in_wb && cdb_gnt;
  assign is_stall = (state_q != IS_EX_IDLE) && !fire;
  assign accept   = rs_is_packet.issue_en && !is_stall && !interrupt;
  assign mem_path = (ctr_cnt == '0);

  assign prf_rd_idx1 = rs_is_packet.decoder_packet.t1.phys_reg;
  assign prf_rd_idx2 = rs_is_packet.decoder_packet.t2.phys_reg;

  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    first_d      = 1'b0;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_dec      = 1'b0;

    case (state_q)
      IS_EX_EXEC: begin
        if (mem_path) begin
          if (mem_done) begin
            result_d = mem_data;
            state_d  = IS_EX_WB;
          end
        end else begin
          ctr_dec = 1'b1;
          if (ctr_last) begin
            result_d = fu_result;
            state_d  = IS_EX_WB;
          end
        end
      end
      IS_EX_WB: begin
        if (fire) state_d = IS_EX_IDLE;
      end
      default: ;
    endcase

    // Accept overrides the WB->IDLE step so back-to-back issue has no bubble.
    if (accept) begin
      pkt_d    = rs_is_packet.decoder_packet;
      opa_d    = (rs_is_packet.decoder_packet.t1.phys_reg == '0) ? '0 : prf_rd_data1;
      opb_d    = (rs_is_packet.decoder_packet.t2.phys_reg == '0) ? '0 : prf_rd_data2;
      state_d  = IS_EX_EXEC;
      first_d  = 1'b1;
      ctr_load = 1'b1;
      case (fu_class_of(rs_is_packet.decoder_packet.alu_func,
                        rs_is_packet.decoder_packet.rd_mem,
                        rs_is_packet.decoder_packet.wr_mem))
        FU_MEM:  ctr_load_val = '0;
        FU_MULT: ctr_load_val = CNT_W'(MULT_LAT);
        default: ctr_load_val = CNT_W'(1);
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || interrupt) begin
      state_q  <= IS_EX_IDLE;
      pkt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pkt_q    <= pkt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      first_q  <= first_d;
    end
  end

  assign fu_valid   = (state_q == IS_EX_EXEC) && first_q;
  assign fu_packet  = pkt_q;
  assign fu_opa     = opa_q;
  assign fu_opb     = opb_q;
  assign cdb_req    = in_wb;
  assign cdb_en     = fire;
  assign cdb_tag    = in_wb ? pkt_q.dest : '0;
  assign cdb_value  = in_wb ? result_q : '0;
  assign ex_rs_packet.remove_en  = fire;
  assign ex_rs_packet.remove_idx = in_wb ? pkt_q.rs_idx : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_is_ex_ctrl.sv
// Bench for is_ex_ctrl: directed scenarios followed by random traffic, all
// checked against a per-instruction timeline model kept in the bench.
module tb_is_ex_ctrl;
  import is_ex_ctrl_pkg::*;

  localparam int MULT_LAT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          interrupt;
  RS_IS_PACKET   rs_is_packet;
  logic          is_stall;
  PHYS_REG_IDX   prf_rd_idx1, prf_rd_idx2;
  DATA           prf_rd_data1, prf_rd_data2;
  logic          fu_valid;
  DECODER_PACKET fu_packet;
  DATA           fu_opa, fu_opb, fu_result;
  logic          mem_done;
  DATA           mem_data;
  logic          cdb_req, cdb_gnt, cdb_en;
  TAG            cdb_tag;
  DATA           cdb_value;
  EX_RS_PACKET   ex_rs_packet;
  IS_EX_STATE    dbg_state;

  DATA prf_mem [64];
  assign prf_rd_data1 = prf_mem[prf_rd_idx1];
  assign prf_rd_data2 = prf_mem[prf_rd_idx2];

  is_ex_ctrl #(.MULT_LAT(MULT_LAT), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .interrupt(interrupt), .rs_is_packet(rs_is_packet),
    .is_stall(is_stall), .prf_rd_idx1(prf_rd_idx1), .prf_rd_idx2(prf_rd_idx2),
    .prf_rd_data1(prf_rd_data1), .prf_rd_data2(prf_rd_data2), .fu_valid(fu_valid),
    .fu_packet(fu_packet), .fu_opa(fu_opa), .fu_opb(fu_opb), .fu_result(fu_result),
    .mem_done(mem_done), .mem_data(mem_data), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt),
    .cdb_tag(cdb_tag), .cdb_en(cdb_en), .cdb_value(cdb_value),
    .ex_rs_packet(ex_rs_packet), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: the instruction in the slot, described by when it was
  // issued and when (if known) it reaches write-back.
  bit            m_valid = 0;
  int            m_issue, m_lat, m_wb_from;
  bit            m_mem, m_wb_known;
  DECODER_PACKET m_pkt;
  DATA           m_opa, m_opb, m_res;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit tb_is_mult(input ALU_FUNC f);
    return f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic DECODER_PACKET mk_pkt(input int rs, input ALU_FUNC f, input bit rd,
                                           input bit wr, input int t1, input int t2,
                                           input int dst);
    DECODER_PACKET p;
    p.rs_idx        = RS_IDX'(rs);
    p.alu_func      = f;
    p.rd_mem        = rd;
    p.wr_mem        = wr;
    p.t1.phys_reg   = PHYS_REG_IDX'(t1);
    p.t2.phys_reg   = PHYS_REG_IDX'(t2);
    p.dest.phys_reg = PHYS_REG_IDX'(dst);
    return p;
  endfunction

  task automatic drive_quiet();
    reset = 0; interrupt = 0; cdb_gnt = 0; mem_done = 0;
    rs_is_packet = '0;
  endtask

  // Inputs are already set; check this cycle's outputs, advance the model, clock.
  task automatic step();
    bit in_wb, fire, stall, accept;
    #1;
    in_wb = m_valid && m_wb_known && (cyc >= m_wb_from);
    fire  = in_wb && cdb_gnt;
    stall = m_valid && !fire;
    check_eq("is_stall",  64'(is_stall), 64'(stall));
    check_eq("fu_valid",  64'(fu_valid), 64'(m_valid && (cyc == m_issue + 1)));
    check_eq("cdb_req",   64'(cdb_req),  64'(in_wb));
    check_eq("cdb_en",    64'(cdb_en),   64'(fire));
    check_eq("remove_en", 64'(ex_rs_packet.remove_en), 64'(fire));
    check_eq("idle_state", 64'(dbg_state == IS_EX_IDLE), 64'(!m_valid));
    if (fire) begin
      check_eq("cdb_tag",    64'(cdb_tag.phys_reg), 64'(m_pkt.dest.phys_reg));
      check_eq("cdb_value",  64'(cdb_value), 64'(m_res));
      check_eq("remove_idx", 64'(ex_rs_packet.remove_idx), 64'(m_pkt.rs_idx));
    end
    if (m_valid) begin
      check_eq("fu_packet", 64'(fu_packet), 64'(m_pkt));
      check_eq("fu_opa",    64'(fu_opa), 64'(m_opa));
      check_eq("fu_opb",    64'(fu_opb), 64'(m_opb));
    end

    accept = rs_is_packet.issue_en && !stall && !interrupt;
    if (reset || interrupt) begin
      m_valid = 0;
    end else begin
      if (m_valid && !in_wb) begin
        if (!m_mem && (cyc == m_issue + m_lat)) begin
          m_res = fu_result; m_wb_known = 1; m_wb_from = cyc + 1;
        end
        if (m_mem && mem_done) begin
          m_res = mem_data; m_wb_known = 1; m_wb_from = cyc + 1;
        end
      end
      if (fire) m_valid = 0;
      if (accept) begin
        m_valid    = 1;
        m_issue    = cyc;
        m_pkt      = rs_is_packet.decoder_packet;
        m_mem      = m_pkt.rd_mem || m_pkt.wr_mem;
        m_lat      = m_mem ? 0 : (tb_is_mult(m_pkt.alu_func) ? MULT_LAT : 1);
        m_wb_known = 0;
        m_opa      = (m_pkt.t1.phys_reg == 0) ? '0 : prf_mem[m_pkt.t1.phys_reg];
        m_opb      = (m_pkt.t2.phys_reg == 0) ? '0 : prf_mem[m_pkt.t2.phys_reg];
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic issue(input DECODER_PACKET p);
    rs_is_packet.issue_en       = 1'b1;
    rs_is_packet.decoder_packet = p;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prf_mem[i] = $urandom;
    prf_mem[0] = 32'hDEAD_BEEF;
    prf_mem[5] = 32'd10;
    prf_mem[6] = 32'd20;
    drive_quiet();
    fu_result = '0; mem_data = '0;
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    check_eq("rst_stall",  64'(is_stall), 64'(0));
    check_eq("rst_fu_val", 64'(fu_valid), 64'(0));
    check_eq("rst_cdbreq", 64'(cdb_req), 64'(0));
    check_eq("rst_cdben",  64'(cdb_en), 64'(0));
    check_eq("rst_remove", 64'(ex_rs_packet.remove_en), 64'(0));

    // ALU add with immediate grant: cdb_en two cycles after accept.
    drive_quiet(); cdb_gnt = 1; fu_result = 32'd30;
    issue(mk_pkt(3, ALU_ADD, 0, 0, 5, 6, 12)); step();
    rs_is_packet.issue_en = 0; step();
    #1;
    check_eq("alu_value", 64'(cdb_value), 64'd30);
    check_eq("alu_tag",   64'(cdb_tag.phys_reg), 64'd12);
    check_eq("alu_ridx",  64'(ex_rs_packet.remove_idx), 64'd3);
    step();
    step();

    // MUL: result presented for the whole run, broadcast MULT_LAT+1 after accept.
    drive_quiet(); cdb_gnt = 1; fu_result = 32'h64;
    issue(mk_pkt(7, ALU_MUL, 0, 0, 0, 9, 20)); step();
    rs_is_packet.issue_en = 0;
    repeat (MULT_LAT + 2) step();

    // Load, late mem_done, CDB grant withheld for 3 cycles.
    drive_quiet(); mem_data = 32'hCAFE_0001;
    issue(mk_pkt(9, ALU_ADD, 1, 0, 5, 0, 33)); step();
    rs_is_packet.issue_en = 0;
    repeat (6) step();
    mem_done = 1; step();
    mem_done = 0; repeat (3) step();
    cdb_gnt = 1; step();
    step();

    // Back-to-back issues with the grant tied high: no idle cycles.
    drive_quiet(); cdb_gnt = 1;
    for (int i = 0; i < 8; i++) begin
      fu_result = $urandom;
      issue(mk_pkt(i, ALU_FUNC'(i % 10), 0, 0, i + 1, 63 - i, 40 + i));
      step();
    end
    drive_quiet(); repeat (3) step();

    // Interrupt during MUL EXEC cycle 2, then a fresh issue right after.
    drive_quiet(); cdb_gnt = 1; fu_result = 32'h1234;
    issue(mk_pkt(2, ALU_MULHU, 0, 0, 5, 6, 7)); step();
    rs_is_packet.issue_en = 0; step();
    interrupt = 1; step();
    interrupt = 0;
    issue(mk_pkt(4, ALU_XOR, 0, 0, 6, 5, 8)); step();
    rs_is_packet.issue_en = 0; repeat (3) step();

    // Reset in WB while granted: fire outputs still visible that cycle.
    drive_quiet(); fu_result = 32'h55;
    issue(mk_pkt(5, ALU_SUB, 0, 0, 5, 6, 9)); step();
    rs_is_packet.issue_en = 0; step();
    step();
    reset = 1; cdb_gnt = 1; step();
    reset = 0; cdb_gnt = 0; step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      reset     = ($urandom_range(0, 199) == 0);
      interrupt = ($urandom_range(0, 49) == 0);
      cdb_gnt   = ($urandom_range(0, 1) == 1);
      mem_done  = ($urandom_range(0, 3) == 0);
      fu_result = $urandom;
      mem_data  = $urandom;
      r = $urandom_range(0, 3);
      rs_is_packet.issue_en = ($urandom_range(0, 9) < 6);
      rs_is_packet.decoder_packet = mk_pkt($urandom_range(0, 15),
                                           ALU_FUNC'($urandom_range(0, 13)),
                                           r == 0, r == 1,
                                           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63),
                                           ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63),
                                           $urandom_range(0, 63));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
